// File: rtl/tf_addr_pkg.sv
// Shared types and constant helpers for the twiddle-factor address sequencer.
// Holds the conf decode, FSM state type and per-stage count/offset functions.
package tf_addr_pkg;

    localparam logic [2:0] CONF_NTT_A = 3'b001;
    localparam logic [2:0] CONF_NTT_B = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_NTT  = 1'b0,
        MODE_INTT = 1'b1
    } mode_t;

    function automatic mode_t conf_mode(input logic [2:0] conf);
        return (conf == CONF_NTT_A || conf == CONF_NTT_B) ? MODE_NTT : MODE_INTT;
    endfunction

    // Stages past the end report zero so padded lookup tables stay harmless.
    function automatic int stage_cnt(input int s, input int num_stages, input int last_cnt);
        if (s >= num_stages) return 0;
        if (s == num_stages - 1) return last_cnt;
        return 1 << (2 * s);
    endfunction

    function automatic int stage_off(input int s, input int num_stages, input int last_cnt);
        int acc;
        acc = 0;
        for (int i = 0; i < s; i++) acc += stage_cnt(i, num_stages, last_cnt);
        return acc;
    endfunction

endpackage

// File: rtl/tf_lane_addr.sv
// One lane of twiddle address generation: maps (stage, index, mode) to an
// address and a validity flag; invalid lanes drive a zero address.
module tf_lane_addr
    import tf_addr_pkg::*;
#(
    parameter int NUM_STAGES     = 5,
    parameter int LAST_STAGE_CNT = 128,
    parameter int ADDR_W         = 8,
    parameter int ST_W           = 3
) (
    input  logic [ST_W-1:0]   s,
    input  logic [ADDR_W:0]   k,
    input  mode_t             mode,
    output logic [ADDR_W-1:0] address,
    output logic              valid
);

    localparam int TAB_N = 2 ** ST_W;
    typedef logic [ADDR_W:0]   cw_t;
    typedef logic [ADDR_W-1:0] aw_t;

    cw_t cnt_tab [TAB_N];
    aw_t off_tab [TAB_N];

    for (genvar i = 0; i < TAB_N; i++) begin : g_tab
        assign cnt_tab[i] = cw_t'(stage_cnt(i, NUM_STAGES, LAST_STAGE_CNT));
        assign off_tab[i] = aw_t'(stage_off(i, NUM_STAGES, LAST_STAGE_CNT));
    end

    cw_t cnt_s;
    aw_t off_s;
    aw_t k_lo;

    assign cnt_s = cnt_tab[s];
    assign off_s = off_tab[s];
    assign k_lo  = k[ADDR_W-1:0];
    assign valid = (k < cnt_s);

    // Valid lanes never exceed the address space, so modulo arithmetic is exact.
    always_comb begin
        address = '0;
        if (valid) begin
            if (mode == MODE_NTT) address = off_s + k_lo;
            else                  address = off_s + cnt_s[ADDR_W-1:0] - aw_t'(1) - k_lo;
        end
    end

endmodule

// File: rtl/tf_address_sequencer.sv
// Walks every transform stage and emits twiddle addresses, NUM_LANES per beat,
// over a valid/ready stream; all outputs come straight from flops.
module tf_address_sequencer
    import tf_addr_pkg::*;
#(
    parameter int NUM_STAGES     = 5,
    parameter int LAST_STAGE_CNT = 128,
    parameter int NUM_LANES      = 1,
    parameter int ADDR_W         = 8,
    localparam int ST_W          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [2:0]                    conf,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES*ADDR_W-1:0]   tf_address,
    output logic [NUM_LANES-1:0]          lane_valid,
    output logic [ST_W-1:0]               stage,
    output logic                          stage_last,
    output logic                          done,
    output state_t                        dbg_state
);

    typedef logic [ADDR_W:0] cw_t;
    localparam int TAB_N = 2 ** ST_W;

    if (stage_off(NUM_STAGES - 1, NUM_STAGES, LAST_STAGE_CNT) + LAST_STAGE_CNT > 2 ** ADDR_W) begin : g_bad_width
        $error("tf_address_sequencer: ADDR_W too small for the address range");
    end
    if (NUM_LANES != 1 && NUM_LANES != 2 && NUM_LANES != 4) begin : g_bad_lanes
        $error("tf_address_sequencer: NUM_LANES must be 1, 2 or 4");
    end

    cw_t cnt_tab [TAB_N];
    for (genvar i = 0; i < TAB_N; i++) begin : g_cnt
        assign cnt_tab[i] = cw_t'(stage_cnt(i, NUM_STAGES, LAST_STAGE_CNT));
    end

    state_t          state_q, state_d;
    logic [ST_W-1:0] s_q, s_d;
    cw_t             kbase_q, kbase_d;
    mode_t           mode_q, mode_d;
    logic            cur_last, nxt_last;

    assign cur_last  = (kbase_q + cw_t'(NUM_LANES)) >= cnt_tab[s_q];
    assign nxt_last  = (kbase_d + cw_t'(NUM_LANES)) >= cnt_tab[s_d];
    assign dbg_state = state_q;

    // Handshake: out_valid is high for the whole of RUN; a beat is consumed on
    // a rising edge with out_valid & out_ready, otherwise every output holds.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        kbase_d = kbase_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    kbase_d = '0;
                    mode_d  = conf_mode(conf);
                end
            end
            ST_RUN: begin
                if (out_ready) begin
                    if (!cur_last) begin
                        kbase_d = kbase_q + cw_t'(NUM_LANES);
                    end else if (s_q == ST_W'(NUM_STAGES - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        s_d     = s_q + ST_W'(1);
                        kbase_d = '0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    logic [NUM_LANES*ADDR_W-1:0] lane_addr;
    logic [NUM_LANES-1:0]        lane_ok;

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
        tf_lane_addr #(
            .NUM_STAGES     (NUM_STAGES),
            .LAST_STAGE_CNT (LAST_STAGE_CNT),
            .ADDR_W         (ADDR_W),
            .ST_W           (ST_W)
        ) u_lane (
            .s       (s_d),
            .k       (kbase_d + cw_t'(j)),
            .mode    (mode_d),
            .address (lane_addr[j*ADDR_W +: ADDR_W]),
            .valid   (lane_ok[j])
        );
    end

    // Output values for the beat that will be presented after the next edge.
    logic                        run_d, busy_d, done_d, stage_last_d;
    logic [ST_W-1:0]             stage_d;
    logic [NUM_LANES-1:0]        lane_valid_d;
    logic [NUM_LANES*ADDR_W-1:0] tf_address_d;

    always_comb begin
        run_d        = (state_d == ST_RUN);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        stage_d      = run_d ? s_d : '0;
        stage_last_d = run_d & nxt_last;
        lane_valid_d = run_d ? lane_ok : '0;
        tf_address_d = run_d ? lane_addr : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            kbase_q    <= '0;
            mode_q     <= MODE_NTT;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            stage      <= '0;
            stage_last <= 1'b0;
            lane_valid <= '0;
            tf_address <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            kbase_q    <= kbase_d;
            mode_q     <= mode_d;
            out_valid  <= run_d;
            busy       <= busy_d;
            done       <= done_d;
            stage      <= stage_d;
            stage_last <= stage_last_d;
            lane_valid <= lane_valid_d;
            tf_address <= tf_address_d;
        end
    end

endmodule

// File: doc/tf_address_sequencer.md
TF_ADDRESS_SEQUENCER -- requirements
Module: tf_address_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 5, giving the number of transform stages.
REQ-002 The block SHALL have parameter LAST_STAGE_CNT, default 128, giving the twiddle count of the final stage.
REQ-003 The block SHALL have parameter NUM_LANES, default 1, one of 1/2/4, giving the addresses emitted per beat.
REQ-004 The block SHALL have parameter ADDR_W, default 8, giving the twiddle address width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port start, input, 1 bit: request one full address sequence.
REQ-008 The block SHALL have port conf, input, 3 bits: mode; 3'b001 or 3'b100 selects NTT, any other value selects INTT.
REQ-009 The block SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the current beat is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the beat.
REQ-012 The block SHALL have port tf_address, output, NUM_LANES*ADDR_W bits: lane j in bits [j*ADDR_W +: ADDR_W].
REQ-013 The block SHALL have port lane_valid, output, NUM_LANES bits: per-lane qualifier.
REQ-014 The block SHALL have port stage, output, clog2(NUM_STAGES) bits: stage index s of the current beat.
REQ-015 The block SHALL have port stage_last, output, 1 bit: the current beat is the last beat of its stage.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse at sequence end.

Function
REQ-017 The stage count SHALL be cnt(s) = 4^s for s < NUM_STAGES-1 and cnt(NUM_STAGES-1) = LAST_STAGE_CNT; the stage offset SHALL be off(s) = sum of cnt(i) for i < s (defaults: off = 0, 1, 5, 21, 85).
REQ-018 The block SHALL iterate s from 0 to NUM_STAGES-1; within each stage kbase SHALL run 0, NUM_LANES, 2*NUM_LANES, ... while kbase < cnt(s).
REQ-019 For lane j, k = kbase+j, and lane_valid[j] SHALL be 1 iff k < cnt(s); address bits of an invalid lane SHALL be 0.
REQ-020 The lane address in NTT mode SHALL be off(s)+k.
REQ-021 The lane address in INTT mode SHALL be off(s)+cnt(s)-1-k.
REQ-022 The FSM SHALL have states IDLE, RUN and DONE.
REQ-023 In IDLE, a cycle with start=1 SHALL latch conf and enter RUN with s=0 and kbase=0; out_valid SHALL rise on the following cycle, and the first beat SHALL be registered.
REQ-024 In RUN, out_valid SHALL be 1; a beat SHALL advance only on out_valid & out_ready, and otherwise all outputs SHALL hold stable.
REQ-025 Acceptance of the final beat (s=NUM_STAGES-1, stage_last=1) SHALL move the FSM to DONE; DONE SHALL assert done for exactly one cycle with out_valid=0 and then return to IDLE.
REQ-026 busy SHALL be 1 in RUN and DONE.
REQ-027 start asserted while busy SHALL be ignored and SHALL NOT queue a request.
REQ-028 A conf change during a sequence SHALL have no effect.
REQ-029 A stage with cnt(s) <= NUM_LANES SHALL emit a single beat with stage_last=1.
REQ-030 Widths SHALL satisfy off(NUM_STAGES-1)+LAST_STAGE_CNT <= 2^ADDR_W, checked by an elaboration-time assertion.
REQ-031 The address arithmetic SHALL NOT wrap.

Reset
REQ-032 While rst=1, at any time including mid-sequence, the block SHALL go to IDLE.
REQ-033 During and after reset, out_valid, busy, done, lane_valid, stage_last, tf_address and stage SHALL all be 0.
REQ-034 The latched mode SHALL reset to NTT.
REQ-035 No beat and no done SHALL appear after reset until a new start.

Structure
REQ-036 The conf encodings, the FSM state type and constant functions cnt(s)/off(s) SHALL live in shared package tf_addr_pkg.
REQ-037 Per-lane address computation SHALL be one sub-module, tf_lane_addr (s, k, mode -> address, valid), instantiated NUM_LANES times.
REQ-038 All outputs SHALL be registered.

Verification
REQ-039 Defaults, conf=3'b001, start pulse, out_ready=1 -> 213 beats with addresses 0,1,2,...,212 in order; stage_last after addresses 0, 4, 20, 84, 212; done one cycle after the last beat.
REQ-040 Defaults, conf=3'b010 -> beat addresses 0; 4,3,2,1; 20..5; 84..21; 212..85; then done.
REQ-041 NUM_LANES=4, NTT -> beat 0 has address 0 with lane_valid=4'b0001; beat 1 has addresses 1,2,3,4 with 4'b1111; 54 beats in total.
REQ-042 out_ready toggled pseudo-randomly -> the address sequence is identical to REQ-039, with outputs stable whenever out_valid=1 and out_ready=0.
REQ-043 rst asserted at beat 30 -> outputs go to 0 immediately; a new start restarts at address 0.
REQ-044 start re-pulsed and conf changed mid-run -> no effect, and exactly one done.
